// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_pkg
// Description : Shared fetch-path definitions: address width, instruction
//               width, default fetch-buffer depth and the canonical layout
//               of one fetch-buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_buffer_pkg;

  localparam int XLEN        = 32;  // address / PC width
  localparam int ILEN        = 32;  // instruction width
  localparam int FETCH_DEPTH = 4;   // default entries / max in-flight requests

  // One fetch-buffer slot at the default address width.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage : fetch_buffer_pkg
`default_nettype wire

// File: rtl/fetch_entry_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_entry_queue
// Description : Circular array of fetch entries. A slot is allocated when
//               its request is accepted, filled when the matching response
//               returns (in order), and dequeued from the head once filled.
//               Allocation, fill and dequeue may all happen in one cycle.
//               A flush empties the queue by collapsing alloc/fill onto head.
// Ports       : clk, rst               - clock, async active-high reset
//               i_flush                - drop all entries
//               i_alloc_en/_pc/_pc_plus_4 - allocate a slot for a request
//               i_fill_en/i_fill_instr - write the next response
//               i_deq_en               - pop the head entry
//               o_count, o_unfilled    - occupancy / allocated-but-empty
//               o_head_*               - head entry payload and filled bit
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_entry_queue
  import fetch_buffer_pkg::*;
#(
  parameter int XLEN  = fetch_buffer_pkg::XLEN,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic                           i_alloc_en,
  input  logic [XLEN-1:0]                i_alloc_pc,
  input  logic [XLEN-1:0]                i_alloc_pc_plus_4,
  input  logic                           i_fill_en,
  input  logic [ILEN-1:0]                i_fill_instr,
  input  logic                           i_deq_en,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic [$clog2(DEPTH+1)-1:0]     o_unfilled,
  output logic                           o_head_filled,
  output logic [XLEN-1:0]                o_head_pc,
  output logic [XLEN-1:0]                o_head_pc_plus_4,
  output logic [ILEN-1:0]                o_head_instr
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0]  r_pc        [DEPTH];
  logic [XLEN-1:0]  r_pc_plus_4 [DEPTH];
  logic [ILEN-1:0]  r_instr     [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [IW-1:0]    r_alloc;
  logic [IW-1:0]    r_fill;
  logic [IW-1:0]    r_head;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_unfilled;

  // Control state. The head slot's filled bit is cleared on dequeue so an
  // empty queue (head == alloc) never presents a stale valid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_filled   <= '0;
    end else if (i_flush) begin
      r_filled   <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_alloc    <= r_head;
      r_fill     <= r_head;
    end else begin
      // Dequeue targets a filled slot, fill an unfilled one and alloc a free
      // one, so the three indices never collide when their enables are set.
      if (i_deq_en) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + IW'(1);
      end
      if (i_alloc_en) begin
        r_filled[r_alloc] <= 1'b0;
        r_alloc           <= r_alloc + IW'(1);
      end
      if (i_fill_en) begin
        r_filled[r_fill] <= 1'b1;
        r_fill           <= r_fill + IW'(1);
      end
      r_count    <= r_count + CW'(i_alloc_en) - CW'(i_deq_en);
      r_unfilled <= r_unfilled + CW'(i_alloc_en) - CW'(i_fill_en);
    end
  end

  // Payload storage carries no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (i_alloc_en && !i_flush) begin
      r_pc[r_alloc]        <= i_alloc_pc;
      r_pc_plus_4[r_alloc] <= i_alloc_pc_plus_4;
    end
    if (i_fill_en && !i_flush) begin
      r_instr[r_fill] <= i_fill_instr;
    end
  end

  assign o_count          = r_count;
  assign o_unfilled       = r_unfilled;
  assign o_head_filled    = r_filled[r_head];
  assign o_head_pc        = r_pc[r_head];
  assign o_head_pc_plus_4 = r_pc_plus_4[r_head];
  assign o_head_instr     = r_instr[r_head];

endmodule : fetch_entry_queue
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Decouples the PC register / instruction memory from decode.
//               Issues one request per cycle while buffer slots plus
//               outstanding flushed requests leave room, stalls the PC
//               otherwise, and presents filled entries to decode in order.
//               A redirect flushes the buffer; responses still owed for the
//               flushed requests are counted in drop_cnt and discarded.
// Ports       : clk, rst                     - clock, async active-high reset
//               pc_in, pc_plus_4_in          - current fetch PC and PC+4
//               redirect                     - taken branch / jump
//               stall_f                      - hold PC register
//               imem_req_valid/_ready/_addr  - request to instruction memory
//               imem_rsp_valid/_data         - in-order response
//               dec_valid/_ready             - handshake to decode
//               dec_instr/_pc/_pc_plus_4     - head entry payload
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int XLEN  = fetch_buffer_pkg::XLEN,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic            redirect,
  output logic            stall_f,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus_4
);

  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_unfilled;
  logic [CW-1:0] r_drop_cnt;
  logic [CW:0]   w_occupancy;
  logic          w_head_filled;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_rsp_drop;
  logic          w_fill;
  logic          w_deq;

  // Slots in use plus responses still owed to flushed requests. Uses the
  // start-of-cycle count only, so a same-cycle dequeue frees no credit.
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};
  assign w_req_valid = !rst && !redirect && (w_occupancy < (CW+1)'(DEPTH));
  assign w_accept    = w_req_valid && imem_req_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = pc_in;

  // Never stall on a redirect so the PC register always takes the target.
  assign stall_f = rst || (!w_accept && !redirect);

  assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_fill     = imem_rsp_valid && !w_rsp_drop && !redirect;

  assign dec_valid = w_head_filled && !redirect;
  assign w_deq     = dec_valid && dec_ready;

  fetch_entry_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk               (clk),
    .rst               (rst),
    .i_flush           (redirect),
    .i_alloc_en        (w_accept),
    .i_alloc_pc        (pc_in),
    .i_alloc_pc_plus_4 (pc_plus_4_in),
    .i_fill_en         (w_fill),
    .i_fill_instr      (imem_rsp_data),
    .i_deq_en          (w_deq),
    .o_count           (w_count),
    .o_unfilled        (w_unfilled),
    .o_head_filled     (w_head_filled),
    .o_head_pc         (dec_pc),
    .o_head_pc_plus_4  (dec_pc_plus_4),
    .o_head_instr      (dec_instr)
  );

  // On redirect every unfilled slot becomes an orphaned request, less the
  // response (if any) that arrives this very cycle and is thrown away now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (redirect) begin
      r_drop_cnt <= r_drop_cnt + w_unfilled - CW'(imem_rsp_valid);
    end else if (w_rsp_drop) begin
      r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  // A response with nothing outstanding means the memory broke protocol.
  a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (w_unfilled == '0) && (r_drop_cnt == '0)));

  a_occupancy_bound : assert property (@(posedge clk) disable iff (rst)
    w_occupancy <= (CW+1)'(DEPTH));

  // Drop counter is consumed by dropped responses; fill and drop never both.
  logic w_unused;
  assign w_unused = ^{pc_plus_4_in[0], w_fill & w_rsp_drop};

endmodule : fetch_buffer
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer. Models the PC register
//               and an in-order fixed-latency instruction memory, applies a
//               table of per-cycle vectors, then hand-written redirect and
//               reset sequences checked against the order of decoded PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_plus_4_in = 32'h4;
  logic        redirect = 1'b0;
  logic        stall_f;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus_4;

  fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_plus_4_in   (pc_plus_4_in),
    .redirect       (redirect),
    .stall_f        (stall_f),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus_4  (dec_pc_plus_4)
  );

  always #5 clk = ~clk;

  // ---------------- models and bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] pc_reg   = '0;
  logic        s_rdr    = 1'b0;
  logic [31:0] s_tgt    = '0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] dec_log[$];

  typedef struct {
    logic        rst_first;
    logic        rdr;
    logic [31:0] tgt;
    logic        rr;
    logic        dr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_dv;
    logic [31:0] e_dpc;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  function automatic vec_t mk(input logic rf, input logic rdr, input logic [31:0] tgt,
                              input logic rr, input logic dr, input logic rv,
                              input logic [31:0] addr, input logic st,
                              input logic dv, input logic [31:0] dpc);
    vec_t v;
    v.rst_first = rf; v.rdr = rdr; v.tgt = tgt; v.rr = rr; v.dr = dr;
    v.e_rv = rv; v.e_addr = addr; v.e_stall = st; v.e_dv = dv; v.e_dpc = dpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
    mq_addr.delete(); mq_due.delete();
    pc_reg = '0; pc_in = '0; pc_plus_4_in = 32'h4;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_stall_f",   32'(stall_f), 32'd1);
    rst = 1'b0;
    cyc = 0;
    dec_log.delete();
  endtask

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic cycle_begin(input logic rdr, input logic [31:0] tgt,
                             input logic rr, input logic dr);
    s_rdr = rdr; s_tgt = tgt;
    redirect = rdr; imem_req_ready = rr; dec_ready = dr;
    pc_in = pc_reg; pc_plus_4_in = pc_reg + 32'd4;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  // Sample handshakes, cross the clock edge, then advance the models.
  task automatic cycle_end();
    logic acc, deq, rsp, stl;
    logic [31:0] a, p, i, p4;
    acc = imem_req_valid && imem_req_ready; a = imem_req_addr;
    deq = dec_valid && dec_ready; p = dec_pc; i = dec_instr; p4 = dec_pc_plus_4;
    rsp = imem_rsp_valid; stl = stall_f;
    @(posedge clk);
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (acc) begin
      mq_addr.push_back(a);
      mq_due.push_back(cyc + lat);
    end
    if (deq) begin
      dec_log.push_back(p);
      check("deq_instr", i, instr_of(p));
      check("deq_pc_plus_4", p4, p + 32'd4);
    end
    if (s_rdr) pc_reg = s_tgt;
    else if (!stl) pc_reg = pc_reg + 32'd4;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rr, input logic dr);
    for (int k = 0; k < n; k++) begin
      cycle_begin(1'b0, '0, rr, dr);
      cycle_end();
    end
  endtask

  // Decoded PCs must be exactly base, base+4, ... with at least min_n entries.
  task automatic check_log(input string name, input logic [31:0] base, input int min_n);
    check({name, "_count_ok"}, 32'(dec_log.size() >= min_n), 32'd1);
    for (int k = 0; k < dec_log.size(); k++)
      check({name, "_pc"}, dec_log[k], base + 32'(4 * k));
  endtask

  initial begin
    // Seq A: streaming, 1-cycle memory, decode always ready.
    tv.push_back(mk(1, 0, 0, 1, 1, 1, 32'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h04, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h08, 0, 1, 32'h0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0C, 0, 1, 32'h4));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h10, 0, 1, 32'h8));
    // Seq B: decode blocked 10 cycles, buffer fills, then drains.
    tv.push_back(mk(1, 0, 0, 1, 0, 1, 32'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 32'h04, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 32'h08, 0, 1, 32'h0));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 32'h0C, 0, 1, 32'h0));
    for (int k = 0; k < 6; k++)
      tv.push_back(mk(0, 0, 0, 1, 0, 0, 32'h10, 1, 1, 32'h0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 32'h10, 1, 1, 32'h0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h10, 0, 1, 32'h4));
    // Seq C: memory not ready, redirect in the middle of the stall.
    tv.push_back(mk(1, 0, 0, 0, 1, 1, 32'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h200, 0, 1, 0, 32'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 32'h200, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h200, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h204, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 32'h208, 0, 1, 32'h200));

    lat = 1;
    for (int v = 0; v < tv.size(); v++) begin
      if (tv[v].rst_first) do_reset();
      cycle_begin(tv[v].rdr, tv[v].tgt, tv[v].rr, tv[v].dr);
      check("req_valid", 32'(imem_req_valid), 32'(tv[v].e_rv));
      check("req_addr",  imem_req_addr, tv[v].e_addr);
      check("stall_f",   32'(stall_f), 32'(tv[v].e_stall));
      check("dec_valid", 32'(dec_valid), 32'(tv[v].e_dv));
      if (tv[v].e_dv) begin
        check("dec_pc",        dec_pc, tv[v].e_dpc);
        check("dec_pc_plus_4", dec_pc_plus_4, tv[v].e_dpc + 32'd4);
        check("dec_instr",     dec_instr, instr_of(tv[v].e_dpc));
      end
      cycle_end();
    end

    // Seq D: 3-cycle memory, redirect with three requests in flight.
    lat = 3;
    do_reset();
    run(3, 1'b1, 1'b1);
    cycle_begin(1'b1, 32'h100, 1'b1, 1'b1);
    check("d_redir_req_valid", 32'(imem_req_valid), 32'd0);
    check("d_redir_stall_f",   32'(stall_f), 32'd0);
    check("d_redir_dec_valid", 32'(dec_valid), 32'd0);
    cycle_end();
    run(10, 1'b1, 1'b1);
    check_log("d_log", 32'h100, 4);

    // Seq E: redirect coincides with a response and a decode handshake.
    lat = 2;
    do_reset();
    run(3, 1'b1, 1'b1);
    cycle_begin(1'b1, 32'h300, 1'b1, 1'b1);
    check("e_rsp_present",     32'(imem_rsp_valid), 32'd1);
    check("e_redir_dec_valid", 32'(dec_valid), 32'd0);
    check("e_redir_req_valid", 32'(imem_req_valid), 32'd0);
    cycle_end();
    run(8, 1'b1, 1'b1);
    check_log("e_log", 32'h300, 3);

    // Seq F: asynchronous reset with two in flight and one filled.
    lat = 2;
    do_reset();
    run(3, 1'b1, 1'b0);
    #2;
    imem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("f_rst_dec_valid", 32'(dec_valid), 32'd0);
    check("f_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("f_rst_stall_f",   32'(stall_f), 32'd1);
    mq_addr.delete(); mq_due.delete();
    pc_reg = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    dec_log.delete();
    lat = 1;
    cycle_begin(1'b0, '0, 1'b1, 1'b1);
    check("f_post_dec_valid", 32'(dec_valid), 32'd0);
    check("f_post_req_valid", 32'(imem_req_valid), 32'd1);
    check("f_post_req_addr",  imem_req_addr, 32'h0);
    check("f_post_stall_f",   32'(stall_f), 32'd0);
    cycle_end();
    run(6, 1'b1, 1'b1);
    check_log("f_log", 32'h0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_buffer
`default_nettype wire
